// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS read scheduler (qos_read_scheduler,
// qos_age_pick, qos_read_scheduler_if).
package qos_pkg;

    localparam int NQ = 5;
    localparam int QW = 3;

    typedef logic [QW-1:0] cls_t;

    localparam cls_t CLS_NORM0 = 3'd0;
    localparam cls_t CLS_NORM1 = 3'd1;
    localparam cls_t CLS_NORM2 = 3'd2;
    localparam cls_t CLS_NORM3 = 3'd3;
    localparam cls_t CLS_HIBW  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/qos_read_scheduler_if.sv
// FIFO-bank read side plus downstream valid/ready bus of the QoS read scheduler.
interface qos_read_scheduler_if #(
    parameter int DSIZE = 32,
    parameter int NQ    = 5
);

    logic [NQ-1:0]       iEmpty;
    logic [NQ*DSIZE-1:0] iRdData;
    logic [NQ-1:0]       oRd;
    logic [DSIZE-1:0]    oData;
    qos_pkg::cls_t       oQoS;
    logic                oValid;
    logic                iReady;

    modport master (
        input  iEmpty, iRdData, iReady,
        output oRd, oData, oQoS, oValid
    );

    modport slave (
        output iEmpty, iRdData, iReady,
        input  oRd, oData, oQoS, oValid
    );

endinterface

// File: rtl/qos_age_pick.sv
// Combinational class picker: strict top class, then aged normal classes,
// then highest non-empty normal class.
module qos_age_pick #(
    parameter int NQ        = qos_pkg::NQ,
    parameter int AGE_LIMIT = 8,
    parameter int AWIDTH    = 4
) (
    input  logic [NQ-1:0]             iEmpty,
    input  logic [NQ-2:0][AWIDTH-1:0] iAge,
    output qos_pkg::cls_t             oSel,
    output logic                      oValid
);
    import qos_pkg::*;

    localparam logic [AWIDTH-1:0] AGE_MAX = AWIDTH'(AGE_LIMIT);

    always_comb begin
        oSel   = '0;
        oValid = 1'b0;
        if (!iEmpty[NQ-1]) begin
            oSel   = cls_t'(NQ - 1);
            oValid = 1'b1;
        end else begin
            // Ascending scans: the last hit is the highest index; an aged hit overrides.
            for (int unsigned k = 0; k < NQ - 1; k++) begin
                if (!iEmpty[k]) begin
                    oSel   = cls_t'(k);
                    oValid = 1'b1;
                end
            end
            for (int unsigned k = 0; k < NQ - 1; k++) begin
                if (!iEmpty[k] && (iAge[k] >= AGE_MAX)) begin
                    oSel = cls_t'(k);
                end
            end
        end
    end

endmodule

// File: rtl/qos_read_scheduler.sv
// QoS read scheduler: pops one class FIFO at a time and presents the word on
// valid/ready. Optional QOS_SCHED_STATS_EN adds grant counters and a starvation flag.
module qos_read_scheduler #(
    parameter int DSIZE     = 32,
    parameter int NQ        = qos_pkg::NQ,
    parameter int AGE_LIMIT = 8,
    parameter int AWIDTH    = 4
) (
    input  logic                 iClk,
    input  logic                 iReset,
    qos_read_scheduler_if.master bus
`ifdef QOS_SCHED_STATS_EN
    ,
    output logic [NQ*16-1:0]     oGrantCnt,
    output logic                 oStarved
`endif
);
    import qos_pkg::*;

    localparam logic [AWIDTH-1:0] AGE_MAX = AWIDTH'(AGE_LIMIT);

    state_e                    state_q, state_d;
    cls_t                      sel_q, sel_d;
    logic [NQ-1:0]             rd_q, rd_d;
    logic [DSIZE-1:0]          data_q, data_d;
    cls_t                      qos_q, qos_d;
    logic                      valid_q, valid_d;
    logic [NQ-2:0][AWIDTH-1:0] age_q, age_d;
    logic                      armed_q, armed_d;
    logic                      take;
    cls_t                      pick_sel;
    logic                      pick_valid;

    qos_age_pick #(
        .NQ        (NQ),
        .AGE_LIMIT (AGE_LIMIT),
        .AWIDTH    (AWIDTH)
    ) u_pick (
        .iEmpty (bus.iEmpty),
        .iAge   (age_q),
        .oSel   (pick_sel),
        .oValid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rd_d    = '0;
        data_d  = data_q;
        qos_d   = qos_q;
        valid_d = valid_q;
        age_d   = age_q;
        armed_d = 1'b1;
        take    = 1'b0;
        unique case (state_q)
            // armed_q keeps the first cycle after reset release free of any selection.
            IDLE: begin
                if (armed_q && pick_valid) begin
                    take    = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                data_d  = bus.iRdData[int'(sel_q)*DSIZE +: DSIZE];
                qos_d   = sel_q;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.iReady) begin
                    valid_d = 1'b0;
                    if (pick_valid) begin
                        take    = 1'b1;
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            sel_d          = pick_sel;
            rd_d[pick_sel] = 1'b1;
            for (int unsigned k = 0; k < NQ - 1; k++) begin
                if (cls_t'(k) == pick_sel || bus.iEmpty[k]) begin
                    age_d[k] = '0;
                end else if (age_q[k] < AGE_MAX) begin
                    age_d[k] = age_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            qos_q   <= '0;
            valid_q <= 1'b0;
            age_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            qos_q   <= qos_d;
            valid_q <= valid_d;
            age_q   <= age_d;
            armed_q <= armed_d;
        end
    end

    assign bus.oRd    = rd_q;
    assign bus.oData  = data_q;
    assign bus.oQoS   = qos_q;
    assign bus.oValid = valid_q;

`ifdef QOS_SCHED_STATS_EN
    logic [NQ-1:0][15:0] grant_q, grant_d;
    logic                starved_q, starved_d;

    always_comb begin
        grant_d   = grant_q;
        starved_d = starved_q;
        if (state_q == POP) begin
            grant_d[sel_q] = grant_q[sel_q] + 16'd1;
        end
        for (int unsigned k = 0; k < NQ - 1; k++) begin
            if (age_q[k] == AGE_MAX) begin
                starved_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            grant_q   <= '0;
            starved_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            starved_q <= starved_d;
        end
    end

    assign oGrantCnt = grant_q;
    assign oStarved  = starved_q;
`endif

endmodule

// File: tb/tb_qos_read_scheduler.sv
// Directed bench for qos_read_scheduler: a FWFT FIFO stub feeds the DUT, table
// vectors plus hand sequences for aging, backpressure and reset.
module tb_qos_read_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    qos_read_scheduler_if #(.DSIZE(32), .NQ(5)) bus ();

`ifdef QOS_SCHED_STATS_EN
    logic [79:0] grant_cnt;
    logic        starved;
`endif

    qos_read_scheduler #(
        .DSIZE     (32),
        .NQ        (5),
        .AGE_LIMIT (8),
        .AWIDTH    (4)
    ) dut (
        .iClk      (clk),
        .iReset    (rst),
        .bus       (bus)
`ifdef QOS_SCHED_STATS_EN
        ,
        .oGrantCnt (grant_cnt),
        .oStarved  (starved)
`endif
    );

    // FIFO stub: head word of class k is A5A5_<popped count><k>
    int unsigned loaded [5] = '{default: 0};
    int unsigned popped [5] = '{default: 0};
    int unsigned bad_pops = 0;

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            bus.iEmpty[k]          = (loaded[k] == popped[k]);
            bus.iRdData[k*32 +: 32] = 32'hA5A5_0000 | ((popped[k] & 32'hFF) << 8) | 32'(k);
        end
    end

    always @(posedge clk) begin
        if ($countones(bus.oRd) > 1) bad_pops <= bad_pops + 1;
        for (int k = 0; k < 5; k++) begin
            if (bus.oRd[k]) begin
                if (loaded[k] == popped[k]) bad_pops <= bad_pops + 1;
                else popped[k] <= popped[k] + 1;
            end
        end
    end

    int unsigned total = 0;
    int unsigned passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.oValid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, "_valid"}, 64'(ok), 64'd1);
    endtask

    task automatic accept();
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit done = 1'b0;
        bus.iReady = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (&bus.iEmpty && !bus.oValid && bus.oRd == '0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        bus.iReady = 1'b0;
        chk(nm, 64'(done), 64'd1);
    endtask

    typedef struct {
        logic [7:0]  ld [5];
        logic [2:0]  qos;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] l4, l3, l2, l1, l0,
                       input logic [2:0] q, input logic [31:0] d);
        vec_t v;
        v.ld[4] = l4; v.ld[3] = l3; v.ld[2] = l2; v.ld[1] = l1; v.ld[0] = l0;
        v.qos = q;
        v.data = d;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0;
        logic [2:0]  q0;
        int unsigned bad;
        int unsigned cyc;
        bit          seen;

        // words to add (class 4..0), expected oQoS, expected oData of next word
        add(0, 1, 0, 1, 0, 3'd3, 32'hA5A5_0003);
        add(0, 0, 0, 0, 0, 3'd1, 32'hA5A5_0001);
        add(2, 0, 1, 0, 1, 3'd4, 32'hA5A5_0004);
        add(0, 0, 0, 0, 0, 3'd4, 32'hA5A5_0104);
        add(0, 0, 0, 0, 0, 3'd2, 32'hA5A5_0002);
        add(0, 0, 0, 0, 0, 3'd0, 32'hA5A5_0000);
        add(4, 4, 4, 4, 4, 3'd4, 32'hA5A5_0204);
        add(0, 0, 0, 0, 0, 3'd4, 32'hA5A5_0304);
        add(0, 0, 0, 0, 0, 3'd4, 32'hA5A5_0404);
        add(0, 0, 0, 0, 0, 3'd4, 32'hA5A5_0504);
        add(0, 0, 0, 0, 0, 3'd3, 32'hA5A5_0103);
        add(0, 0, 0, 0, 0, 3'd3, 32'hA5A5_0203);
        add(0, 0, 0, 0, 0, 3'd3, 32'hA5A5_0303);
        add(0, 0, 0, 0, 0, 3'd3, 32'hA5A5_0403);
        add(0, 0, 0, 0, 0, 3'd2, 32'hA5A5_0102);
        add(0, 0, 0, 0, 0, 3'd1, 32'hA5A5_0101);
        add(0, 0, 0, 0, 0, 3'd0, 32'hA5A5_0100);

        bus.iReady = 1'b0;
        tick();
        tick();
        chk("rst_rd",    64'(bus.oRd),    64'd0);
        chk("rst_valid", 64'(bus.oValid), 64'd0);
        chk("rst_data",  64'(bus.oData),  64'd0);
        chk("rst_qos",   64'(bus.oQoS),   64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            for (int k = 0; k < 5; k++) loaded[k] += 32'(vecs[i].ld[k]);
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_qos", i),  64'(bus.oQoS),  64'(vecs[i].qos));
            chk($sformatf("vec%0d_data", i), 64'(bus.oData), 64'(vecs[i].data));
            accept();
        end
        drain("drain_table");

        // Aging: class 0 must win on grants 9 and 18 while class 3 stays busy
        loaded[0] += 20;
        loaded[3] += 20;
        for (int g = 1; g <= 18; g++) begin
            wait_valid($sformatf("starve%0d", g));
            chk($sformatf("starve%0d_qos", g), 64'(bus.oQoS), (g == 9 || g == 18) ? 64'd0 : 64'd3);
            accept();
        end
        drain("drain_starve");

`ifdef QOS_SCHED_STATS_EN
        chk("stats_starved", 64'(starved), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stats_grant%0d", k), 64'(grant_cnt[k*16 +: 16]), 64'(loaded[k] & 32'hFFFF));
        end
`endif

        // Backpressure: word held for 10 cycles, class 2 arrives meanwhile
        loaded[1] += 1;
        wait_valid("bp");
        d0 = bus.oData;
        q0 = bus.oQoS;
        chk("bp_qos",  64'(q0), 64'd1);
        chk("bp_data", 64'(d0), 64'hA5A5_0501);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) loaded[2] += 1;
            tick();
            if (bus.oData !== d0 || bus.oQoS !== q0 || bus.oRd !== 5'b0 || bus.oValid !== 1'b1) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        accept();
        chk("bp_pop_next", 64'(bus.oRd), 64'b00100);
        tick();
        chk("bp_pop_once", 64'(bus.oRd), 64'd0);
        chk("bp2_qos",  64'(bus.oQoS),  64'd2);
        chk("bp2_data", 64'(bus.oData), 64'hA5A5_0502);
        drain("drain_bp");

        // Reset while holding a word, class 0 waiting across release
        loaded[4] += 1;
        wait_valid("mid");
        chk("mid_qos", 64'(bus.oQoS), 64'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.oValid), 64'd0);
        chk("mid_rst_rd",    64'(bus.oRd),    64'd0);
        chk("mid_rst_data",  64'(bus.oData),  64'd0);
        loaded[0] += 1;
        tick();
        rst = 1'b0;
        tick();
        chk("rel_rd_first", 64'(bus.oRd), 64'd0);
        cyc = 1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.oRd != '0) begin
                seen = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        chk("rel_rd_seen", 64'(seen), 64'd1);
        chk("rel_rd_late", 64'(cyc >= 2), 64'd1);
        chk("rel_rd",      64'(bus.oRd),  64'b00001);
        tick();
        chk("rel_qos",  64'(bus.oQoS),  64'd0);
        chk("rel_data", 64'(bus.oData), 64'hA5A5_1900);
        drain("drain_rel");

        chk("no_bad_pops", 64'(bad_pops), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
